// File: rtl/vape_er_session_ctrl.sv
// vape_er_session_ctrl: ER bound registers and ARMED/RUN/DONE/FAIL sequencing for VAPE monitors (optional VIOLS counter: VAPE_VIOL_CNT_EN)
module vape_er_session_ctrl #(
    parameter logic [15:0] CFG_BASE = 16'h0190,
    parameter int NMON = 4
) (
    input  logic            clk,
    input  logic            puc_rst,
    input  logic [15:0]     pc,
    input  logic [15:0]     data_addr,
    input  logic            data_wr,
    input  logic [15:0]     data_wdata,
    output logic [15:0]     cfg_rdata,
    input  logic [NMON-1:0] mon_exec,
    output logic [15:0]     ER_min,
    output logic [15:0]     ER_max,
    output logic            mon_arm,
    output logic            exec,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, RUN = 3'd2, DONE = 3'd3, FAIL = 3'd4} state_t;
    state_t state, nxt;
    logic [15:0] cycles, viols_rd;
    logic wr_min, wr_max, wr_ctrl, arm, clr, er_wr, viol, locked, cfg_ok;
    assign wr_min  = data_wr && data_addr == CFG_BASE;
    assign wr_max  = data_wr && data_addr == CFG_BASE + 16'h2;
    assign wr_ctrl = data_wr && data_addr == CFG_BASE + 16'h4;
    assign clr     = wr_ctrl && data_wdata[1];
    assign arm     = wr_ctrl && data_wdata[0] && !data_wdata[1];
    assign er_wr   = wr_min || wr_max;
    assign viol    = !(&mon_exec);
    assign locked  = state == ARMED || state == RUN;
    assign cfg_ok  = ER_min <= ER_max && !ER_min[0];
    // next-state selection; violations always win over progress
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, FAIL: nxt = (clr && state != IDLE) ? IDLE : arm ? (cfg_ok ? ARMED : FAIL) : state;
            ARMED: nxt = (viol || arm || er_wr) ? FAIL : pc == ER_min ? RUN : ARMED;
            RUN: nxt = (viol || arm || er_wr || pc < ER_min || pc > ER_max) ? FAIL : pc == ER_max ? DONE : RUN;
            default: nxt = IDLE;
        endcase
    end
    // session state, bound registers, run-cycle counter and registered status outputs
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state   <= IDLE;
            ER_min  <= '0;
            ER_max  <= '0;
            cycles  <= '0;
            exec    <= 1'b0;
            mon_arm <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= nxt;
            if (wr_min && !locked) ER_min <= data_wdata;
            if (wr_max && !locked) ER_max <= data_wdata;
            cycles  <= (arm && !locked) ? 16'h0 : (state == RUN && cycles != 16'hFFFF) ? cycles + 16'd1 : cycles;
            exec    <= nxt == DONE;
            mon_arm <= nxt == ARMED || nxt == RUN;
            busy    <= nxt == ARMED || nxt == RUN;
        end
    end
`ifdef VAPE_VIOL_CNT_EN
    logic [7:0] viols;
    logic fail_evt;
    assign fail_evt = nxt == FAIL && (state != FAIL || arm);
    // saturating count of FAIL entries, cleared only by reset
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) viols <= '0;
        else if (fail_evt && viols != 8'hFF) viols <= viols + 8'd1;
    end
    assign viols_rd = {8'h00, viols};
`else
    assign viols_rd = 16'h0000;
`endif
    // register read mux; CTRL bits are self-clearing so CTRL reads 0
    always_comb begin
        cfg_rdata = data_addr == CFG_BASE ? ER_min :
                    data_addr == CFG_BASE + 16'h2 ? ER_max :
                    data_addr == CFG_BASE + 16'h6 ? {13'd0, state} :
                    data_addr == CFG_BASE + 16'h8 ? cycles :
                    data_addr == CFG_BASE + 16'hA ? viols_rd : 16'h0000;
    end
endmodule

// File: tb/tb_vape_er_session_ctrl.sv
// tb_vape_er_session_ctrl: scoreboard bench for the ER session controller
module tb_vape_er_session_ctrl;
    localparam logic [15:0] B = 16'h0190;
    localparam logic [15:0] O_MIN = 16'h0, O_MAX = 16'h2, O_CTRL = 16'h4, O_ST = 16'h6, O_CYC = 16'h8, O_VIOL = 16'hA;
    localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_RUN = 3'd2, S_DONE = 3'd3, S_FAIL = 3'd4;
    logic clk = 0, puc_rst = 1, data_wr = 0, mon_arm, exec, busy;
    logic [15:0] pc = 0, data_addr = 0, data_wdata = 0, cfg_rdata, ER_min, ER_max;
    logic [3:0] mon_exec = 4'hF;
    logic [2:0] exp_q[$];
    int n_tests = 0, n_fail = 0;
    vape_er_session_ctrl dut (
        .clk(clk), .puc_rst(puc_rst), .pc(pc), .data_addr(data_addr), .data_wr(data_wr),
        .data_wdata(data_wdata), .cfg_rdata(cfg_rdata), .mon_exec(mon_exec),
        .ER_min(ER_min), .ER_max(ER_max), .mon_arm(mon_arm), .exec(exec), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic rd(input logic [15:0] off, input logic [15:0] exp, input string tag);
        data_wr = 0;
        data_addr = B + off;
        #1;
        chk(tag, {16'h0, cfg_rdata}, {16'h0, exp});
    endtask
    task automatic cyc(input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                       input logic [15:0] p, input logic [3:0] m, input logic [2:0] exp_st, input string tag);
        logic [2:0] e;
        data_addr = addr;
        data_wr = wr;
        data_wdata = wd;
        pc = p;
        mon_exec = m;
        exp_q.push_back(exp_st);
        @(posedge clk);
        #1;
        data_wr = 0;
        data_addr = B + O_ST;
        mon_exec = 4'hF;
        #1;
        e = exp_q.pop_front();
        chk({tag, " status"}, {16'h0, cfg_rdata}, {29'h0, e});
        chk({tag, " exec"}, {31'h0, exec}, {31'h0, e == S_DONE});
        chk({tag, " mon_arm"}, {31'h0, mon_arm}, {31'h0, e == S_ARMED || e == S_RUN});
        chk({tag, " busy"}, {31'h0, busy}, {31'h0, e == S_ARMED || e == S_RUN});
    endtask
    task automatic wr(input logic [15:0] off, input logic [15:0] d, input logic [2:0] exp_st, input string tag);
        cyc(B + off, 1'b1, d, 16'h0, 4'hF, exp_st, tag);
    endtask
    task automatic step(input logic [15:0] p, input logic [3:0] m, input logic [2:0] exp_st, input string tag);
        cyc(B + O_ST, 1'b0, 16'h0, p, m, exp_st, tag);
    endtask
    initial begin
`ifdef VAPE_VIOL_CNT_EN
        logic [15:0] viol_exp = 16'd6;
`else
        logic [15:0] viol_exp = 16'd0;
`endif
        #12 puc_rst = 0;
        #1;
        rd(O_ST, 16'h0, "rst status");
        rd(O_CYC, 16'h0, "rst cycles");
        rd(O_VIOL, 16'h0, "rst viols");
        chk("rst outs", {13'h0, exec, mon_arm, busy}, 32'h0);
        chk("rst ermin", {16'h0, ER_min}, 32'h0);
        chk("rst ermax", {16'h0, ER_max}, 32'h0);
        @(posedge clk); #1;
        wr(O_MIN, 16'hE000, S_IDLE, "nom wmin");
        wr(O_MAX, 16'hE0FE, S_IDLE, "nom wmax");
        chk("nom ermin", {16'h0, ER_min}, 32'hE000);
        chk("nom ermax", {16'h0, ER_max}, 32'hE0FE);
        rd(O_CTRL, 16'h0, "ctrl reads 0");
        wr(O_CTRL, 16'h1, S_ARMED, "nom arm");
        step(16'hE000, 4'hF, S_RUN, "nom enter");
        for (int a = 16'hE002; a <= 16'hE0FE; a += 2)
            step(a[15:0], 4'hF, a == 16'hE0FE ? S_DONE : S_RUN, "nom run");
        step(16'h0000, 4'hF, S_DONE, "nom hold");
        rd(O_CYC, 16'd127, "nom cycles");
        wr(O_MIN, 16'hE100, S_DONE, "bad wmin");
        wr(O_MAX, 16'hE000, S_DONE, "bad wmax");
        wr(O_CTRL, 16'h1, S_FAIL, "bad arm");
        rd(O_CYC, 16'h0, "bad cycles clr");
        wr(O_CTRL, 16'h2, S_IDLE, "bad clr");
        wr(O_MIN, 16'hE000, S_IDLE, "vio wmin");
        wr(O_MAX, 16'hE0FE, S_IDLE, "vio wmax");
        wr(O_CTRL, 16'h1, S_ARMED, "vio arm");
        step(16'hE000, 4'hF, S_RUN, "vio enter");
        step(16'hE002, 4'hF, S_RUN, "vio run");
        step(16'hE004, 4'b1011, S_FAIL, "vio hit");
        step(16'hE0FE, 4'hF, S_FAIL, "vio no done");
        wr(O_CTRL, 16'h2, S_IDLE, "vio clr");
        wr(O_CTRL, 16'h1, S_ARMED, "col arm");
        step(16'hE000, 4'hF, S_RUN, "col enter");
        step(16'hE0FE, 4'b1110, S_FAIL, "col hit");
        wr(O_CTRL, 16'h2, S_IDLE, "col clr");
        wr(O_CTRL, 16'h1, S_ARMED, "lock arm");
        wr(O_MAX, 16'hFFFF, S_FAIL, "lock wmax");
        chk("lock ermax", {16'h0, ER_max}, 32'hE0FE);
        wr(O_CTRL, 16'h2, S_IDLE, "lock clr");
        wr(O_MIN, 16'hE050, S_IDLE, "eq wmin");
        wr(O_MAX, 16'hE050, S_IDLE, "eq wmax");
        wr(O_CTRL, 16'h1, S_ARMED, "eq arm");
        step(16'hE050, 4'hF, S_RUN, "eq enter");
        step(16'hE050, 4'hF, S_DONE, "eq done");
        rd(O_CYC, 16'd1, "eq cycles");
        wr(O_CTRL, 16'h2, S_IDLE, "eq clr");
        wr(O_MIN, 16'hE001, S_IDLE, "odd wmin");
        wr(O_MAX, 16'hE0FE, S_IDLE, "odd wmax");
        wr(O_CTRL, 16'h1, S_FAIL, "odd arm");
        wr(O_CTRL, 16'h2, S_IDLE, "odd clr");
        wr(O_MIN, 16'hE000, S_IDLE, "oor wmin");
        wr(O_CTRL, 16'h1, S_ARMED, "oor arm");
        step(16'hE000, 4'hF, S_RUN, "oor enter");
        step(16'hE100, 4'hF, S_FAIL, "oor exit");
        wr(O_CTRL, 16'h2, S_IDLE, "oor clr");
        wr(O_ST, 16'hFFFF, S_IDLE, "ro status");
        wr(O_CYC, 16'h1234, S_IDLE, "ro cycles");
        rd(O_CYC, 16'd1, "ro cycles val");
        wr(O_VIOL, 16'h00AA, S_IDLE, "ro viols");
        rd(O_VIOL, viol_exp, "viols count");
        wr(O_CTRL, 16'h1, S_ARMED, "mid arm");
        step(16'hE000, 4'hF, S_RUN, "mid enter");
        step(16'hE002, 4'hF, S_RUN, "mid run");
        #2 puc_rst = 1;
        #1;
        chk("mid outs", {13'h0, exec, mon_arm, busy}, 32'h0);
        chk("mid ermin", {16'h0, ER_min}, 32'h0);
        rd(O_ST, 16'h0, "mid status");
        rd(O_CYC, 16'h0, "mid cycles");
        rd(O_VIOL, 16'h0, "mid viols");
        @(posedge clk); #1;
        puc_rst = 0;
        step(16'hE000, 4'hF, S_IDLE, "post rst");
        chk("queue empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
